// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_pkg
//  Description : Shared constants, FSM state encoding and the pixel slice
//                helper for the HUB75 panel receiver.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package hub75_pkg;

    localparam int COLS  = 64;               // pixels per row before a latch
    localparam int ROW_W = 4;                // {D,C,B,A}
    localparam int PIX_W = 3;                // {R,G,B}

    localparam int CNT_W = 7;                // sample counter, saturates at 127
    localparam int IDX_W = $clog2(COLS);     // capture slot index width

    localparam logic [CNT_W-1:0] CNT_COLS = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    // LSB position of pixel k inside a packed row bus.
    function automatic int pix_slice(input int k);
        return k * PIX_W;
    endfunction

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/hub75_half_capture.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_half_capture
//  Description : One half-panel row capture buffer. Each pixel slot has its
//                own write enable decoded from wr_idx, so the k-th sample of
//                a row always lands in slot k regardless of pauses.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                wr_en       - write rgb into slot wr_idx this cycle
//                wr_idx      - target slot
//                rgb         - {R,G,B} sample
//                clr         - clear every slot (takes priority over wr_en)
//                capture     - packed row, pixel k at [k*PIX_W +: PIX_W]
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_half_capture
    import hub75_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [PIX_W-1:0]      rgb,
    input  logic                  clr,
    output logic [COLS*PIX_W-1:0] capture
);

    genvar k;
    generate
        for (k = 0; k < COLS; k++) begin : g_pix
            logic [PIX_W-1:0] r_pix;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pix <= '0;
                end else if (clr) begin
                    r_pix <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(k))) begin
                    r_pix <= rgb;
                end
            end

            assign capture[pix_slice(k) +: PIX_W] = r_pix;
        end
    endgenerate

endmodule : hub75_half_capture
`default_nettype wire

// File: rtl/hub75_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_panel_rx
//  Description : Receiving end of a HUB75 LED matrix link. Samples the upper
//                and lower RGB streams while OE is high, and on each LAT
//                rising edge publishes both captured rows, the row address,
//                the sample count, a sticky row-length error and a
//                frame-done pulse on the last row address.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                A,B,C,D             - row address, D is MSB
//                R0,G0,B0 / R1,G1,B1 - upper / lower pixel data
//                OE                  - high = shifting phase
//                LAT                 - latch strobe
//                row_valid           - 1-cycle pulse, row_* updated
//                row_addr            - {D,C,B,A} sampled at the latch
//                row_top / row_bot   - captured rows, pixel k at [k*3 +: 3]
//                pix_count           - samples taken for the latched row
//                len_err             - sticky, a row had pix_count != COLS
//                frame_done          - pulse on a latch of the last row
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_panel_rx
    import hub75_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  A,
    input  logic                  B,
    input  logic                  C,
    input  logic                  D,
    input  logic                  R0,
    input  logic                  G0,
    input  logic                  B0,
    input  logic                  R1,
    input  logic                  G1,
    input  logic                  B1,
    input  logic                  OE,
    input  logic                  LAT,
    output logic                  row_valid,
    output logic [ROW_W-1:0]      row_addr,
    output logic [COLS*PIX_W-1:0] row_top,
    output logic [COLS*PIX_W-1:0] row_bot,
    output logic [CNT_W-1:0]      pix_count,
    output logic                  len_err,
    output logic                  frame_done
);

    logic [1:0]            r_state;
    logic                  r_latQ;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rowValid;
    logic [ROW_W-1:0]      r_rowAddr;
    logic [COLS*PIX_W-1:0] r_rowTop;
    logic [COLS*PIX_W-1:0] r_rowBot;
    logic [CNT_W-1:0]      r_pixCount;
    logic                  r_lenErr;
    logic                  r_frameDone;

    logic                  w_latRise;
    logic                  w_sample;
    logic                  w_wrEn;
    logic [ROW_W-1:0]      w_addr;
    logic [COLS*PIX_W-1:0] w_capTop;
    logic [COLS*PIX_W-1:0] w_capBot;

    // Only the rising edge of LAT latches; a long LAT pulse gives one row.
    assign w_latRise = LAT & ~r_latQ;
    // A cycle with LAT high is never a pixel, which also gives the latch
    // priority over a sample arriving in the same cycle.
    assign w_sample  = OE & ~LAT;
    // Samples past the end of the row are counted but not stored.
    assign w_wrEn    = w_sample & (r_cnt < CNT_COLS);
    assign w_addr    = {D, C, B, A};

    hub75_half_capture u_capTop (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wrEn),
        .wr_idx  (r_cnt[IDX_W-1:0]),
        .rgb     ({R0, G0, B0}),
        .clr     (w_latRise),
        .capture (w_capTop)
    );

    hub75_half_capture u_capBot (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wrEn),
        .wr_idx  (r_cnt[IDX_W-1:0]),
        .rgb     ({R1, G1, B1}),
        .clr     (w_latRise),
        .capture (w_capBot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_latQ      <= 1'b0;
            r_cnt       <= '0;
            r_rowValid  <= 1'b0;
            r_rowAddr   <= '0;
            r_rowTop    <= '0;
            r_rowBot    <= '0;
            r_pixCount  <= '0;
            r_lenErr    <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_latQ      <= LAT;
            r_rowValid  <= w_latRise;
            r_frameDone <= w_latRise & (&w_addr);

            if (w_latRise) begin
                r_rowTop   <= w_capTop;
                r_rowBot   <= w_capBot;
                r_rowAddr  <= w_addr;
                r_pixCount <= r_cnt;
                r_cnt      <= '0;
                if (r_cnt != CNT_COLS) begin
                    r_lenErr <= 1'b1;
                end
            end else if (w_sample && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_latRise) begin
                        r_state <= LATCH;
                    end else if (w_sample) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Dropping OE pauses the row; the count is kept.
                    if (w_latRise) begin
                        r_state <= LATCH;
                    end else if (!OE && !LAT) begin
                        r_state <= IDLE;
                    end
                end
                LATCH: begin
                    r_state <= w_sample ? SHIFT : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign row_valid  = r_rowValid;
    assign row_addr   = r_rowAddr;
    assign row_top    = r_rowTop;
    assign row_bot    = r_rowBot;
    assign pix_count  = r_pixCount;
    assign len_err    = r_lenErr;
    assign frame_done = r_frameDone;

endmodule : hub75_panel_rx
`default_nettype wire

// File: tb/tb_hub75_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_panel_rx
//  Description : Self-checking bench for hub75_panel_rx. A queue-based model
//                collects the pixels shifted since the last latch and builds
//                the expected row words, count and flags from them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hub75_panel_rx;

    localparam int NCOL = 64;
    localparam int RW   = NCOL * 3;

    logic clk = 1'b0;
    logic rst_n;
    logic A, B, C, D;
    logic R0, G0, B0, R1, G1, B1;
    logic OE, LAT;
    logic          row_valid;
    logic [3:0]    row_addr;
    logic [RW-1:0] row_top;
    logic [RW-1:0] row_bot;
    logic [6:0]    pix_count;
    logic          len_err;
    logic          frame_done;

    hub75_panel_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .R0         (R0),
        .G0         (G0),
        .B0         (B0),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .OE         (OE),
        .LAT        (LAT),
        .row_valid  (row_valid),
        .row_addr   (row_addr),
        .row_top    (row_top),
        .row_bot    (row_bot),
        .pix_count  (pix_count),
        .len_err    (len_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int validSeen = 0;
    int frameSeen = 0;

    // Reference model state
    logic [2:0]    qTop[$];
    logic [2:0]    qBot[$];
    bit            mLenErr;
    logic [RW-1:0] expTop, expBot;
    logic [6:0]    expCnt;
    logic [3:0]    expAddr;
    logic          expFrame;

    always @(negedge clk) begin
        if (row_valid === 1'b1)  validSeen++;
        if (frame_done === 1'b1) frameSeen++;
    end

    task automatic shift_px(input logic [2:0] t, input logic [2:0] b);
        @(negedge clk);
        OE = 1'b1; LAT = 1'b0;
        {R0, G0, B0} = t;
        {R1, G1, B1} = b;
        {D, C, B, A} = 4'($urandom);
        qTop.push_back(t);
        qBot.push_back(b);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        OE = 1'b0; LAT = 1'b0;
    endtask

    task automatic send_random(input int n, input bit pauses);
        for (int i = 0; i < n; i++) begin
            if (pauses && ($urandom_range(0, 7) == 0)) idle_cycle();
            shift_px(3'($urandom), 3'($urandom));
        end
    endtask

    // Drives the LAT rising edge and computes what the row outputs must show.
    task automatic start_latch(input logic [3:0] addr, input bit oe, input logic [2:0] rgb);
        @(negedge clk);
        LAT = 1'b1; OE = oe;
        {D, C, B, A} = addr;
        {R0, G0, B0} = rgb;
        {R1, G1, B1} = rgb;
        expTop = '0;
        expBot = '0;
        for (int k = 0; k < NCOL; k++) begin
            if (k < qTop.size()) begin
                expTop[k*3 +: 3] = qTop[k];
                expBot[k*3 +: 3] = qBot[k];
            end
        end
        expCnt   = (qTop.size() > 127) ? 7'd127 : 7'(qTop.size());
        if (qTop.size() != NCOL) mLenErr = 1'b1;
        expAddr  = addr;
        expFrame = (addr == 4'hF);
        qTop.delete();
        qBot.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT} = '0;
        mLenErr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({row_valid, row_addr, row_top, row_bot, frame_done} !== '0) begin
            bad++; $display("FAIL reset_rows: got valid=%b addr=%h top=%h bot=%h fd=%b, want all 0",
                            row_valid, row_addr, row_top, row_bot, frame_done);
        end
        total++;
        if ({pix_count, len_err} !== 8'd0) begin
            bad++; $display("FAIL reset_cnt: got pix_count=%0d len_err=%b, want 0 0", pix_count, len_err);
        end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_row0();
        for (int k = 0; k < NCOL; k++) shift_px(3'(k), ~3'(k));
        start_latch(4'd0, 1'b0, 3'b000);
        @(negedge clk);
        total++; if (row_valid !== 1'b1)   begin bad++; $display("FAIL row0_valid: got %b want 1", row_valid); end
        total++; if (row_addr !== 4'd0)    begin bad++; $display("FAIL row0_addr: got %h want 0", row_addr); end
        total++; if (row_top[2:0] !== 3'b000) begin bad++; $display("FAIL row0_pix0: got %b want 000", row_top[2:0]); end
        total++; if (row_top[191:189] !== 3'b111) begin bad++; $display("FAIL row0_pix63: got %b want 111", row_top[191:189]); end
        total++; if (row_top !== expTop)   begin bad++; $display("FAIL row0_top: got %h want %h", row_top, expTop); end
        total++; if (row_bot !== expBot)   begin bad++; $display("FAIL row0_bot: got %h want %h", row_bot, expBot); end
        total++; if (pix_count !== 7'd64)  begin bad++; $display("FAIL row0_count: got %0d want 64", pix_count); end
        total++; if (len_err !== 1'b0)     begin bad++; $display("FAIL row0_lenerr: got %b want 0", len_err); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL row0_frame: got %b want 0", frame_done); end
        LAT = 1'b0; OE = 1'b0;
        @(negedge clk);
        total++; if (row_valid !== 1'b0)   begin bad++; $display("FAIL row0_pulse: got %b want 0", row_valid); end
        total++; if (row_top !== expTop)   begin bad++; $display("FAIL row0_hold: got %h want %h", row_top, expTop); end
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = validSeen; f0 = frameSeen;
        for (int r = 0; r < 16; r++) begin
            send_random(NCOL, 1'b1);
            start_latch(4'(r), 1'b0, 3'($urandom));
            @(negedge clk);
            total++; if (row_valid !== 1'b1) begin bad++; $display("FAIL frame_valid r%0d: got %b want 1", r, row_valid); end
            total++; if (row_addr !== expAddr) begin bad++; $display("FAIL frame_addr r%0d: got %h want %h", r, row_addr, expAddr); end
            total++; if ({row_top, row_bot} !== {expTop, expBot}) begin
                bad++; $display("FAIL frame_data r%0d: got %h/%h want %h/%h", r, row_top, row_bot, expTop, expBot);
            end
            total++; if (frame_done !== expFrame) begin bad++; $display("FAIL frame_done r%0d: got %b want %b", r, frame_done, expFrame); end
            total++; if (len_err !== mLenErr) begin bad++; $display("FAIL frame_lenerr r%0d: got %b want %b", r, len_err, mLenErr); end
            LAT = 1'b0; OE = 1'b0;
        end
        idle_cycle(); idle_cycle();
        total++; if (validSeen - v0 !== 16) begin bad++; $display("FAIL frame_pulses: got %0d want 16", validSeen - v0); end
        total++; if (frameSeen - f0 !== 1)  begin bad++; $display("FAIL frame_count: got %0d want 1", frameSeen - f0); end
    endtask

    task automatic test_short_row();
        send_random(10, 1'b0);
        start_latch(4'($urandom_range(0, 14)), 1'b0, 3'b000);
        @(negedge clk);
        total++; if (pix_count !== 7'd10) begin bad++; $display("FAIL short_count: got %0d want 10", pix_count); end
        total++; if (len_err !== 1'b1)    begin bad++; $display("FAIL short_lenerr: got %b want 1", len_err); end
        total++; if (row_top[191:30] !== '0) begin bad++; $display("FAIL short_dark: got %h want 0", row_top[191:30]); end
        total++; if ({row_top, row_bot} !== {expTop, expBot}) begin
            bad++; $display("FAIL short_data: got %h/%h want %h/%h", row_top, row_bot, expTop, expBot);
        end
        LAT = 1'b0; OE = 1'b0;
        send_random(NCOL, 1'b1);
        start_latch(4'($urandom), 1'b0, 3'b000);
        @(negedge clk);
        total++; if (pix_count !== 7'd64) begin bad++; $display("FAIL short_next_count: got %0d want 64", pix_count); end
        total++; if (len_err !== 1'b1)    begin bad++; $display("FAIL short_sticky: got %b want 1", len_err); end
        total++; if (row_top !== expTop)  begin bad++; $display("FAIL short_next_top: got %h want %h", row_top, expTop); end
        LAT = 1'b0; OE = 1'b0;
    endtask

    task automatic test_overrun();
        int v0;
        send_random(70, 1'b0);
        v0 = validSeen;
        start_latch(4'($urandom), 1'b0, 3'b000);
        @(negedge clk);
        total++; if (pix_count !== expCnt) begin bad++; $display("FAIL over_count: got %0d want %0d", pix_count, expCnt); end
        total++; if ({row_top, row_bot} !== {expTop, expBot}) begin
            bad++; $display("FAIL over_data: got %h/%h want %h/%h", row_top, row_bot, expTop, expBot);
        end
        repeat (4) @(negedge clk);
        LAT = 1'b0; OE = 1'b0;
        idle_cycle(); idle_cycle();
        total++; if (validSeen - v0 !== 1) begin bad++; $display("FAIL over_longlat: got %0d pulses want 1", validSeen - v0); end
        // Count saturation
        send_random(130, 1'b0);
        start_latch(4'($urandom), 1'b0, 3'b000);
        @(negedge clk);
        total++; if (pix_count !== expCnt) begin bad++; $display("FAIL over_sat: got %0d want %0d", pix_count, expCnt); end
        LAT = 1'b0; OE = 1'b0;
    endtask

    task automatic test_lat_priority();
        send_random(20, 1'b0);
        start_latch(4'($urandom), 1'b1, 3'b111);
        @(negedge clk);
        total++; if (pix_count !== 7'd20) begin bad++; $display("FAIL prio_count: got %0d want 20", pix_count); end
        total++; if (row_top[62:60] !== 3'b000) begin bad++; $display("FAIL prio_slot: got %b want 000", row_top[62:60]); end
        total++; if ({row_top, row_bot} !== {expTop, expBot}) begin
            bad++; $display("FAIL prio_data: got %h/%h want %h/%h", row_top, row_bot, expTop, expBot);
        end
        LAT = 1'b0; OE = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset_midrow();
        send_random(30, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; OE = 1'b0; LAT = 1'b0;
        qTop.delete(); qBot.delete();
        mLenErr = 1'b0;
        @(negedge clk);
        total++;
        if ({row_valid, row_addr, row_top, row_bot, pix_count, len_err, frame_done} !== '0) begin
            bad++; $display("FAIL midreset_zero: got cnt=%0d lenerr=%b top=%h, want all 0", pix_count, len_err, row_top);
        end
        rst_n = 1'b1;
        idle_cycle();
        send_random(NCOL, 1'b1);
        start_latch(4'($urandom), 1'b0, 3'b000);
        @(negedge clk);
        total++; if (row_valid !== 1'b1)   begin bad++; $display("FAIL midreset_valid: got %b want 1", row_valid); end
        total++; if (pix_count !== 7'd64)  begin bad++; $display("FAIL midreset_count: got %0d want 64", pix_count); end
        total++; if (len_err !== 1'b0)     begin bad++; $display("FAIL midreset_lenerr: got %b want 0", len_err); end
        total++; if ({row_top, row_bot} !== {expTop, expBot}) begin
            bad++; $display("FAIL midreset_data: got %h/%h want %h/%h", row_top, row_bot, expTop, expBot);
        end
        LAT = 1'b0; OE = 1'b0;
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_row0();
        test_back_to_back();
        test_short_row();
        test_overrun();
        test_lat_priority();
        test_reset_midrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hub75_panel_rx
`default_nettype wire
